// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and types for the UART receive block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [7:0] ADDR_RX_DATA = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h04;
    localparam logic [7:0] ADDR_BAUD    = 8'h08;
    localparam logic [7:0] ADDR_CTRL    = 8'h0C;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_RX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int OVS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous FIFO for received bytes plus frame-error tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_CNT = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees a slot on the same edge, so a push while full still lands.
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != c_FULL_CNT) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= din;
    end

    assign dout  = r_mem[r_rptr];
    assign full  = (r_count == c_FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_rx_regs.sv
// ============================================================================
// Module      : uart_rx_regs
// Description : 8N1 UART receiver with 16x oversampling, RX FIFO, register port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_regs
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        cs,
    input  logic [7:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rx_irq
);

    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;

    logic            r_rx_meta, r_rx_s;
    logic [15:0]     r_baud_div, r_baud_cnt;
    logic [15:0]     w_div_m1;
    logic            w_tick;
    logic            r_rx_en, r_irq_en;
    logic            r_overrun, r_frame_err;
    logic [31:0]     r_rdata;

    rx_state_e       r_state, w_state_nxt;
    logic [3:0]      r_tick_cnt, w_tick_nxt;
    logic [2:0]      r_bit_idx, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            r_need_idle, w_need_idle_nxt;
    logic            w_push;

    logic            w_rd, w_wr, w_pop, w_ovr_set, w_fe_set;
    logic            w_full, w_empty;
    logic [8:0]      w_fifo_dout;
    logic [c_CW-1:0] w_count;
    logic [31:0]     w_status, w_rd_mux;
    logic            w_unused_ok;

    assign w_rd = cs && !we;
    assign w_wr = cs && we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // A divider of 0 behaves as 1, i.e. a tick every clock.
    assign w_div_m1 = (r_baud_div == 16'd0) ? 16'd0 : r_baud_div - 16'd1;
    assign w_tick   = r_rx_en && (r_baud_cnt >= w_div_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
        end else if (!r_rx_en || (w_wr && addr == ADDR_BAUD) || w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tick_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_need_idle <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_need_idle <= w_need_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tick_nxt      = r_tick_cnt;
        w_bit_nxt       = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_need_idle_nxt = r_need_idle;
        w_push          = 1'b0;
        // After a low stop bit the line must be seen high on a tick before re-arming.
        if (w_tick && r_rx_s) w_need_idle_nxt = 1'b0;
        if (!r_rx_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_rx_s && !r_need_idle) begin
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == 4'd7) begin
                            w_tick_nxt  = '0;
                            w_state_nxt = r_rx_s ? IDLE : DATA;
                        end else begin
                            w_tick_nxt = r_tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        w_tick_nxt = r_tick_cnt + 4'd1;
                        if (r_tick_cnt == 4'(OVS - 1)) begin
                            w_shift_nxt[r_bit_idx] = r_rx_s;
                            w_bit_nxt = r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) w_state_nxt = STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        w_tick_nxt = r_tick_cnt + 4'd1;
                        if (r_tick_cnt == 4'(OVS - 1)) begin
                            w_push      = 1'b1;
                            w_state_nxt = IDLE;
                            if (!r_rx_s) w_need_idle_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_pop     = w_rd && (addr == ADDR_RX_DATA) && !w_empty;
    assign w_ovr_set = w_push && w_full && !w_pop;
    assign w_fe_set  = w_push && !r_rx_s;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   ({~r_rx_s, r_shift}),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        w_status                        = '0;
        w_status[ST_NOT_EMPTY]          = !w_empty;
        w_status[ST_FULL]               = w_full;
        w_status[ST_OVERRUN]            = r_overrun;
        w_status[ST_FRAME_ERR]          = r_frame_err;
        w_status[ST_COUNT_LSB +: 8]     = 8'(w_count);
    end

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            ADDR_RX_DATA: if (!w_empty) w_rd_mux = {23'd0, w_fifo_dout};
            ADDR_STATUS:  w_rd_mux = w_status;
            ADDR_BAUD:    w_rd_mux = {16'd0, r_baud_div};
            ADDR_CTRL:    w_rd_mux = {30'd0, r_irq_en, r_rx_en};
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata     <= '0;
            r_baud_div  <= DEFAULT_DIV;
            r_rx_en     <= 1'b0;
            r_irq_en    <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_rd) r_rdata <= w_rd_mux;
            if (w_wr && addr == ADDR_BAUD) r_baud_div <= wdata[15:0];
            if (w_wr && addr == ADDR_CTRL) begin
                r_rx_en  <= wdata[CTRL_RX_EN];
                r_irq_en <= wdata[CTRL_IRQ_EN];
            end
            // Set beats a simultaneous write-one-to-clear.
            r_overrun   <= w_ovr_set | (r_overrun &
                           ~(w_wr && addr == ADDR_STATUS && wdata[ST_OVERRUN]));
            r_frame_err <= w_fe_set | (r_frame_err &
                           ~(w_wr && addr == ADDR_STATUS && wdata[ST_FRAME_ERR]));
        end
    end

    assign rdata       = r_rdata;
    assign rx_irq      = !w_empty && r_irq_en;
    assign w_unused_ok = &{1'b0, wdata[31:16]};

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_regs.sv
// ============================================================================
// Module      : tb_uart_rx_regs
// Description : Self-checking bench for uart_rx_regs with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_regs;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, rx, cs, we;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata, rd;
    logic        rx_irq;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vt [16];
    logic [8:0]  mq [$];
    logic        m_ovr, m_fe;

    always #5 clk = ~clk;

    uart_rx_regs #(
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd27)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .cs     (cs),
        .addr   (addr),
        .we     (we),
        .wdata  (wdata),
        .rdata  (rdata),
        .rx_irq (rx_irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        d = rdata;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
        @(negedge clk);
        rx = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bclk) @(negedge clk);
        end
        rx = stop;
        repeat (bclk) @(negedge clk);
        rx = 1'b1;
    endtask

    function automatic logic [31:0] model_status();
        int n = mq.size();
        return (32'(n) << 8) | {28'd0, m_fe, m_ovr, (n == DEPTH), (n != 0)};
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        m_ovr = 1'b0; m_fe = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'd0, rx_irq}, 32'h0);

        vt[0]  = '{ADDR_STATUS,  1'b0, 32'h0,        32'h0,    "rst_status"};
        vt[1]  = '{ADDR_BAUD,    1'b0, 32'h0,        32'd27,   "rst_baud"};
        vt[2]  = '{ADDR_CTRL,    1'b0, 32'h0,        32'h0,    "rst_ctrl"};
        vt[3]  = '{ADDR_RX_DATA, 1'b0, 32'h0,        32'h0,    "rxdata_empty"};
        vt[4]  = '{8'h20,        1'b0, 32'h0,        32'h0,    "unmapped_rd"};
        vt[5]  = '{ADDR_BAUD,    1'b1, 32'hFFFF_ABCD, 32'h0,   "wr_baud"};
        vt[6]  = '{ADDR_BAUD,    1'b0, 32'h0,        32'hABCD, "baud_rw"};
        vt[7]  = '{ADDR_CTRL,    1'b1, 32'hFFFF_FFFF, 32'h0,   "wr_ctrl"};
        vt[8]  = '{ADDR_CTRL,    1'b0, 32'h0,        32'h3,    "ctrl_rw"};
        vt[9]  = '{ADDR_CTRL,    1'b1, 32'h0,        32'h0,    "wr_ctrl0"};
        vt[10] = '{8'h20,        1'b1, 32'hFFFF_FFFF, 32'h0,   "wr_unmapped"};
        vt[11] = '{8'h20,        1'b0, 32'h0,        32'h0,    "unmapped_after_wr"};
        vt[12] = '{ADDR_RX_DATA, 1'b1, 32'h1FF,      32'h0,    "wr_rxdata"};
        vt[13] = '{ADDR_STATUS,  1'b0, 32'h0,        32'h0,    "status_after_rxdata_wr"};
        vt[14] = '{ADDR_BAUD,    1'b1, 32'h0,        32'h0,    "wr_baud0"};
        vt[15] = '{ADDR_BAUD,    1'b0, 32'h0,        32'h0,    "baud_zero_rd"};
        for (int i = 0; i < 16; i++) begin
            if (vt[i].we) bus_write(vt[i].addr, vt[i].wdata);
            else begin
                bus_read(vt[i].addr, rd);
                check(vt[i].name, rd, vt[i].exp);
            end
        end

        // Single good frame
        bus_write(ADDR_BAUD, 32'd4);
        bus_write(ADDR_CTRL, 32'd3);
        send_frame(8'hA5, 1'b1, 64);
        repeat (8) @(negedge clk);
        bus_read(ADDR_STATUS, rd);   check("t2_status", rd, 32'h0101);
        check("t2_irq", {31'd0, rx_irq}, 32'h1);
        bus_read(ADDR_RX_DATA, rd);  check("t2_data", rd, 32'h0A5);
        bus_read(ADDR_STATUS, rd);   check("t2_status_after", rd, 32'h0);
        check("t2_irq_after", {31'd0, rx_irq}, 32'h0);

        // Framing error
        send_frame(8'h3C, 1'b0, 64);
        repeat (16) @(negedge clk);
        bus_read(ADDR_RX_DATA, rd);  check("t3_data", rd, 32'h13C);
        bus_read(ADDR_STATUS, rd);   check("t3_status", rd, 32'h0008);
        bus_write(ADDR_STATUS, 32'h8);
        bus_read(ADDR_STATUS, rd);   check("t3_cleared", rd, 32'h0);

        // Overrun with 17 frames
        for (int k = 0; k < 17; k++) begin
            send_frame(8'(k), 1'b1, 64);
            repeat (16) @(negedge clk);
        end
        bus_read(ADDR_STATUS, rd);   check("t4_status", rd, 32'h1007);
        bus_write(ADDR_STATUS, 32'h0);
        bus_read(ADDR_STATUS, rd);   check("t4_status_w0", rd, 32'h1007);
        for (int k = 0; k < 16; k++) begin
            bus_read(ADDR_RX_DATA, rd);
            check($sformatf("t4_data%0d", k), rd, 32'(k));
        end
        bus_read(ADDR_STATUS, rd);   check("t4_status_end", rd, 32'h0004);
        bus_write(ADDR_STATUS, 32'h4);

        // False start
        @(negedge clk); rx = 1'b0;
        repeat (5) @(negedge clk); rx = 1'b1;
        repeat (100) @(negedge clk);
        bus_read(ADDR_STATUS, rd);   check("t5_status", rd, 32'h0);
        send_frame(8'h55, 1'b1, 64);
        repeat (16) @(negedge clk);
        bus_read(ADDR_RX_DATA, rd);  check("t5_data", rd, 32'h055);

        // Disable during bit 3
        fork
            send_frame(8'hFF, 1'b1, 64);
            begin
                repeat (64 * 4 + 24) @(negedge clk);
                bus_write(ADDR_CTRL, 32'h0);
            end
        join
        repeat (16) @(negedge clk);
        bus_read(ADDR_STATUS, rd);   check("t6_status", rd, 32'h0);
        bus_write(ADDR_CTRL, 32'h3);
        send_frame(8'h81, 1'b1, 64);
        repeat (16) @(negedge clk);
        bus_read(ADDR_RX_DATA, rd);  check("t6_data", rd, 32'h081);

        // Randomized frames vs queue model
        for (int r = 0; r < 3; r++) begin
            int div, bclk, n;
            div  = $urandom_range(0, 3);
            bclk = 16 * ((div == 0) ? 1 : div);
            n    = $urandom_range(1, 18);
            bus_write(ADDR_BAUD, 32'(div));
            for (int k = 0; k < n; k++) begin
                logic [7:0] b;
                logic       stop;
                b    = 8'($urandom);
                stop = ($urandom_range(0, 3) != 0);
                send_frame(b, stop, bclk);
                repeat ($urandom_range(12, 30)) @(negedge clk);
                if (mq.size() < DEPTH) mq.push_back({~stop, b});
                else m_ovr = 1'b1;
                if (!stop) m_fe = 1'b1;
            end
            bus_read(ADDR_STATUS, rd);
            check($sformatf("rnd%0d_status", r), rd, model_status());
            check($sformatf("rnd%0d_irq", r), {31'd0, rx_irq}, {31'd0, mq.size() != 0});
            while (mq.size() != 0) begin
                logic [8:0] e;
                e = mq.pop_front();
                bus_read(ADDR_RX_DATA, rd);
                check($sformatf("rnd%0d_data", r), rd, {23'd0, e});
            end
            bus_read(ADDR_RX_DATA, rd);
            check($sformatf("rnd%0d_empty_rd", r), rd, 32'h0);
            bus_write(ADDR_STATUS, 32'hC);
            m_ovr = 1'b0; m_fe = 1'b0;
            bus_read(ADDR_STATUS, rd);
            check($sformatf("rnd%0d_cleared", r), rd, model_status());
        end

        // Reset in the middle of a frame with data buffered
        bus_write(ADDR_BAUD, 32'd4);
        send_frame(8'h42, 1'b1, 64);
        repeat (16) @(negedge clk);
        fork
            send_frame(8'h99, 1'b1, 64);
            begin
                repeat (200) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (16) @(negedge clk);
        check("mid_rst_irq", {31'd0, rx_irq}, 32'h0);
        bus_read(ADDR_STATUS, rd);   check("mid_rst_status", rd, 32'h0);
        bus_read(ADDR_BAUD, rd);     check("mid_rst_baud", rd, 32'd27);
        bus_read(ADDR_CTRL, rd);     check("mid_rst_ctrl", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
